// File: rtl/commit_ctrl.sv
// In-order commit sequencer: retires the ROB head into the register file, hands stores to the
// load/store buffer and drives the clear/redirect/stall sequence after a mispredicted branch.
module commit_ctrl #(
  parameter int NICK_W      = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int RECOVER_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iROB_head_vld,
  input  logic              iROB_head_done,
  input  logic [4:0]        iROB_head_regnm,
  input  logic [DATA_W-1:0] iROB_head_dt,
  input  logic [NICK_W-1:0] iROB_head_nick,
  input  logic              iROB_head_store,
  input  logic              iROB_head_mispd,
  input  logic [ADDR_W-1:0] iROB_head_target,
  output logic              oROB_pop,
  output logic              oRF_en,
  output logic [4:0]        oRF_regnm,
  output logic [DATA_W-1:0] oRF_dt,
  output logic [NICK_W-1:0] oRF_nick,
  output logic              oRF_clr,
  output logic              oLSB_store_go,
  input  logic              iLSB_store_ack,
  output logic              oIF_redirect_en,
  output logic [ADDR_W-1:0] oIF_redirect_pc,
  output logic              oStall,
  output logic [31:0]       oCommit_cnt
);

  localparam int CNT_W = (RECOVER_CYC < 2) ? 1 : $clog2(RECOVER_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STORE,
    FLUSH,
    RECOVER
  } state_t;

  state_t            state;
  logic              pop_q;
  logic              rf_en_q;
  logic              rf_clr_q;
  logic              store_go_q;
  logic              redirect_q;
  logic [CNT_W-1:0]  rec_cnt;
  logic [4:0]        br_regnm;
  logic [DATA_W-1:0] br_dt;
  logic [ADDR_W-1:0] br_target;
  logic              head_ready;
  logic              head_writes;

  // A pop in flight means the ROB head has not advanced yet, so it must not be re-evaluated.
  assign head_ready  = iROB_head_vld & iROB_head_done & ~pop_q;
  assign head_writes = (iROB_head_regnm != 5'd0);

  // Strobes are held while frozen and only become visible once rdy returns.
  assign oROB_pop        = pop_q & rdy;
  assign oRF_en          = rf_en_q & rdy;
  assign oRF_clr         = rf_clr_q & rdy;
  assign oLSB_store_go   = store_go_q & rdy;
  assign oIF_redirect_en = redirect_q & rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pop_q           <= 1'b0;
      rf_en_q         <= 1'b0;
      rf_clr_q        <= 1'b0;
      store_go_q      <= 1'b0;
      redirect_q      <= 1'b0;
      rec_cnt         <= '0;
      br_regnm        <= 5'd0;
      br_dt           <= '0;
      br_target       <= '0;
      oRF_regnm       <= 5'd0;
      oRF_dt          <= '0;
      oRF_nick        <= '0;
      oIF_redirect_pc <= '0;
      oStall          <= 1'b0;
      oCommit_cnt     <= 32'd0;
    end else if (rdy) begin
      pop_q      <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_clr_q   <= 1'b0;
      store_go_q <= 1'b0;
      redirect_q <= 1'b0;

      if (pop_q) begin
        oCommit_cnt <= oCommit_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          if (head_ready) begin
            if (iROB_head_mispd) begin
              pop_q     <= 1'b1;
              rf_en_q   <= head_writes;
              if (head_writes) begin
                oRF_regnm <= iROB_head_regnm;
                oRF_dt    <= iROB_head_dt;
                oRF_nick  <= iROB_head_nick;
              end
              br_regnm  <= iROB_head_regnm;
              br_dt     <= iROB_head_dt;
              br_target <= iROB_head_target;
              state     <= FLUSH;
            end else if (iROB_head_store) begin
              store_go_q <= 1'b1;
              state      <= WAIT_STORE;
            end else begin
              pop_q   <= 1'b1;
              rf_en_q <= head_writes;
              if (head_writes) begin
                oRF_regnm <= iROB_head_regnm;
                oRF_dt    <= iROB_head_dt;
                oRF_nick  <= iROB_head_nick;
              end
            end
          end
        end

        WAIT_STORE: begin
          if (iLSB_store_ack && !store_go_q) begin
            pop_q <= 1'b1;
            state <= IDLE;
          end
        end

        // The register file writes regnm/dt alongside the clear, so they carry the branch result.
        FLUSH: begin
          rf_clr_q        <= 1'b1;
          redirect_q      <= 1'b1;
          oIF_redirect_pc <= br_target;
          oRF_regnm       <= br_regnm;
          oRF_dt          <= (br_regnm == 5'd0) ? '0 : br_dt;
          oStall          <= 1'b1;
          rec_cnt         <= CNT_W'(RECOVER_CYC);
          state           <= RECOVER;
        end

        RECOVER: begin
          if (rec_cnt == '0) begin
            oStall <= 1'b0;
            state  <= IDLE;
          end else begin
            rec_cnt <= rec_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

In-order commit sequencer between the reorder buffer head and the register file's commit/clear ports. It retires one completed ROB head entry at a time and writes the result and its rename tag (nick) into the register file. Stores are handed to the load/store buffer and held until the buffer acknowledges them. On a mispredicted branch it drives the register-file clear, redirects fetch, and stalls the front end for a fixed recovery window.

## Interface
Parameters:
- NICK_W, 4, rename tag width; nick 0 means "not renamed", ROB tags are 1..2^NICK_W-1
- DATA_W, 32, register data width
- ADDR_W, 32, PC width
- RECOVER_CYC, 2, front-end stall cycles after a flush (≥1)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; 0 freezes the block
- iROB_head_vld  in  1  ROB non-empty
- iROB_head_done  in  1  head entry has its result
- iROB_head_regnm  in  5  destination register (0 = no write)
- iROB_head_dt  in  DATA_W  result data
- iROB_head_nick  in  NICK_W  head's tag
- iROB_head_store  in  1  head is a store
- iROB_head_mispd  in  1  head is a mispredicted branch/jump
- iROB_head_target  in  ADDR_W  correct next PC for a mispredict
- oROB_pop  out  1  retire head (1-cycle strobe)
- oRF_en  out  1  register-file commit strobe
- oRF_regnm  out  5  commit register
- oRF_dt  out  DATA_W  commit data
- oRF_nick  out  NICK_W  commit tag
- oRF_clr  out  1  register-file clear strobe
- oLSB_store_go  out  1  release head store (1-cycle strobe)
- iLSB_store_ack  in  1  store performed
- oIF_redirect_en  out  1  fetch redirect strobe
- oIF_redirect_pc  out  ADDR_W  redirect target
- oStall  out  1  hold fetch/dispatch
- oCommit_cnt  out  32  retired-instruction count

## Operation
- States: IDLE, WAIT_STORE, FLUSH, RECOVER.
- All outputs are registered. Registers update only when rdy=1.
- Every strobe output (oROB_pop, oRF_en, oRF_clr, oLSB_store_go, oIF_redirect_en) is the registered value ANDed with rdy.
  - A strobe registered while rdy=0 therefore appears on the first rdy=1 cycle.
  - It is cleared on that same cycle's update.
- IDLE: the head is evaluated only when iROB_head_vld & iROB_head_done and oROB_pop was not asserted in the current cycle (one-cycle retire bubble; at most 1 retire per 2 cycles).
  - Normal entry, regnm≠0: register oRF_en=1, regnm/dt/nick from head, and oROB_pop=1. Stay in IDLE.
  - Normal entry, regnm=0: register oROB_pop=1 only. oRF_en=0.
  - Store: register oLSB_store_go=1 and go to WAIT_STORE.
  - Mispredict: register the normal commit (oRF_en iff regnm≠0) plus oROB_pop=1. Latch regnm, dt and target. Go to FLUSH.
  - Mispredict has priority over store if both flags are set. That combination is illegal upstream, but must still be handled.
- WAIT_STORE: wait for iLSB_store_ack.
  - Ack is ignored in the cycle oLSB_store_go is high.
  - On ack: register oROB_pop=1 (oRF_en=0) and go to IDLE.
- FLUSH (1 cycle of outputs):
  - oRF_clr=1 and oIF_redirect_en=1, with oIF_redirect_pc = latched target.
  - oRF_regnm/oRF_dt carry the latched branch rd/data, because the register file writes them on clear. If rd=0, drive dt=0.
  - oRF_en=0. oStall=1.
  - Go to RECOVER with counter = RECOVER_CYC.
- RECOVER: oStall=1. Decrement the counter each cycle; go to IDLE when it reaches 0. Head inputs are ignored.
- oCommit_cnt increments by 1 in the cycle oROB_pop is high; wraps mod 2^32.
- rst (any state, mid-store or mid-flush included):
  - state = IDLE.
  - All outputs 0, including oCommit_cnt, oRF_* fields and oIF_redirect_pc.
  - Recovery counter = 0. Latched branch fields = 0.

## Timing
- Normal retire: head done at cycle N → oRF_en and oROB_pop high at N+1 for exactly 1 cycle. The next head is evaluated at N+2.
- Store: done at N → oLSB_store_go at N+1. Ack at cycle M ≥ N+2 → oROB_pop at M+1.
- Mispredict: done at N → commit + pop at N+1. oRF_clr + oIF_redirect_en + oStall at N+2. oStall stays high through N+2+RECOVER_CYC. Back in IDLE and evaluating at N+3+RECOVER_CYC.
- oStall is low in IDLE and WAIT_STORE.
- rdy=0 for k cycles delays every edge above by k. No strobe is lost or duplicated.

## Test plan
- Reset then 3 done heads (x5=0x11/nick1, x0/nick2, x6=0x22/nick3):
  - oRF_en pulses twice only (x5, then x6).
  - oROB_pop pulses 3 times, each 2 cycles apart.
  - oCommit_cnt = 3.
- Store head, ack held low 5 cycles:
  - oLSB_store_go pulses once at N+1.
  - No pop until the cycle after ack.
  - oRF_en stays 0 throughout.
- Mispredict jal, x1=0x1004, target 0x2000, RECOVER_CYC=2:
  - N+1: commit of x1.
  - N+2: oRF_clr=1, oRF_regnm=1, oRF_dt=0x1004, oIF_redirect_pc=0x2000.
  - oStall high N+2..N+4.
  - A done head presented at N+2 is not popped before N+5.
- rdy dropped for 3 cycles the cycle after a head is accepted:
  - oRF_en and oROB_pop stay 0 during the drop.
  - Each appears exactly once on the first rdy=1 cycle.
- rst asserted in WAIT_STORE and in RECOVER: next cycle all outputs 0 and state is IDLE. A late iLSB_store_ack produces no pop.
- oCommit_cnt preloaded near wrap (0xFFFFFFFF via 2^32-1 retires, or force) → next pop gives 0.
